// File: rtl/dmem_write_buffer.sv
// -----------------------------------------------------------------------------
// dmem_write_buffer
//
// Posted-write buffer between the CPU data-memory port and a word-addressed
// data RAM. Stores are queued in a small circular FIFO and drained to the RAM
// one per cycle while the RAM reports ready. Loads are forwarded from the
// youngest pending store to the same word, so the CPU always reads the latest
// stored value even while that store is still queued.
//
// Parameters
//   DEPTH      FIFO entries (power of two, 2..16)
//   AW         word-index width; the index is cpu_addr[AW+1:2]
//
// Ports
//   clk        clock, all state updates on posedge
//   rst        asynchronous active-high reset, discards pending entries
//   cpu_addr   byte address from the CPU (bits [1:0] ignored)
//   cpu_wdata  store data from the CPU
//   cpu_we     store request
//   cpu_rdata  load data to the CPU (forwarded or ram_rdata), combinational
//   cpu_stall  store cannot be accepted this cycle, combinational
//   ram_rdata  RAM combinational read data at cpu_addr[AW+1:2]
//   ram_ready  RAM accepts a write this cycle
//   ram_waddr  word index of the head entry
//   ram_wdata  data of the head entry
//   ram_we     head entry valid (buffer not empty)
//   count      current occupancy
//   empty      occupancy is zero
// -----------------------------------------------------------------------------
module dmem_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 14
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                cpu_addr,
    input  logic [31:0]                cpu_wdata,
    input  logic                       cpu_we,
    output logic [31:0]                cpu_rdata,
    output logic                       cpu_stall,
    input  logic [31:0]                ram_rdata,
    input  logic                       ram_ready,
    output logic [AW-1:0]              ram_waddr,
    output logic [31:0]                ram_wdata,
    output logic                       ram_we,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt;

    logic [AW-1:0] cpu_idx;
    logic          full;
    logic          push;
    logic          pop;

    assign cpu_idx   = cpu_addr[AW+1:2];
    assign full      = (cnt == CW'(DEPTH));

    // A full buffer still accepts a store when the head drains in the same
    // cycle, since the freed slot and the new entry swap on one edge.
    assign cpu_stall = cpu_we && full && !ram_ready;
    assign push      = cpu_we && !cpu_stall;
    assign pop       = ram_we && ram_ready;

    assign ram_we    = (cnt != '0);
    assign ram_waddr = addr_mem[rd_ptr];
    assign ram_wdata = data_mem[rd_ptr];
    assign count     = cnt;
    assign empty     = (cnt == '0);

    // Forwarding: walk the valid entries from oldest to youngest so the
    // youngest match overwrites any older one. The head entry still counts
    // while it is being popped; a store being pushed this cycle does not.
    always_comb begin
        // NOTE: give every always_comb output a default before any branch,
        // otherwise a path that skips the assignment infers a latch.
        cpu_rdata = ram_rdata;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            logic [PW-1:0] idx;
            idx = wr_ptr - PW'(i + 1);
            if ((CW'(i) < cnt) && (addr_mem[idx] == cpu_idx)) begin
                cpu_rdata = data_mem[idx];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            // NOTE: the entry storage is cleared on reset so the head outputs
            // read zero afterwards; this keeps it in flops rather than RAM.
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            if (push) begin
                addr_mem[wr_ptr] <= cpu_idx;
                data_mem[wr_ptr] <= cpu_wdata;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_write_buffer.sv
// -----------------------------------------------------------------------------
// tb_dmem_write_buffer
//
// Directed self-checking bench for dmem_write_buffer (DEPTH=4, AW=14).
// Inputs are driven 1 time unit after the rising edge; outputs are checked
// before the next rising edge. RAM writes are logged on the falling edge.
// -----------------------------------------------------------------------------
module tb_dmem_write_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 14;

    logic                    clk;
    logic                    rst;
    logic [31:0]             cpu_addr;
    logic [31:0]             cpu_wdata;
    logic                    cpu_we;
    logic [31:0]             cpu_rdata;
    logic                    cpu_stall;
    logic [31:0]             ram_rdata;
    logic                    ram_ready;
    logic [AW-1:0]           ram_waddr;
    logic [31:0]             ram_wdata;
    logic                    ram_we;
    logic [$clog2(DEPTH):0]  count;
    logic                    empty;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];

    dmem_write_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .ram_rdata (ram_rdata),
        .ram_ready (ram_ready),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .count     (count),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs only change just after posedge, so the falling edge sees the
    // values that the next rising edge will act on.
    always @(negedge clk) begin
        if (!rst && ram_we && ram_ready) begin
            log_addr.push_back(32'(ram_waddr));
            log_data.push_back(ram_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        cpu_we    = 1'b1;
        cpu_addr  = addr;
        cpu_wdata = data;
        step();
        cpu_we    = 1'b0;
    endtask

    logic [31:0] exp_a [4];
    logic [31:0] exp_d [4];

    initial begin
        bit tog;
        bit accepted;
        int budget;

        rst       = 1'b1;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_we    = 1'b0;
        ram_rdata = 32'hDEAD_BEEF;
        ram_ready = 1'b0;

        // ---------------- reset and idle ----------------
        step();
        rst = 1'b0;
        #1;
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_ram_we", 32'(ram_we), 0);
        check("rst_stall", 32'(cpu_stall), 0);
        check("rst_rdata", cpu_rdata, 32'hDEAD_BEEF);
        check("rst_waddr", 32'(ram_waddr), 0);
        check("rst_wdata", ram_wdata, 0);

        // ---------------- drain order ----------------
        step();
        store(32'h0, 32'h11);
        store(32'h4, 32'h22);
        store(32'h8, 32'h33);
        check("drain_count", 32'(count), 3);
        check("drain_we", 32'(ram_we), 1);
        step();
        check("hold_waddr", 32'(ram_waddr), 0);
        check("hold_wdata", ram_wdata, 32'h11);
        ram_ready = 1'b1;
        exp_a = '{32'd0, 32'd1, 32'd2, 32'd0};
        exp_d = '{32'h11, 32'h22, 32'h33, 32'h0};
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("drain_waddr%0d", k), 32'(ram_waddr), exp_a[k]);
            check($sformatf("drain_wdata%0d", k), ram_wdata, exp_d[k]);
            step();
        end
        check("drain_empty", 32'(empty), 1);
        check("empty_ready_we", 32'(ram_we), 0);
        step();
        check("empty_ready_count", 32'(count), 0);

        // ---------------- forwarding ----------------
        ram_ready = 1'b0;
        store(32'h10, 32'hA);
        store(32'h10, 32'hB);
        cpu_addr  = 32'h10;
        ram_rdata = 32'h0;
        #1;
        check("fwd_youngest", cpu_rdata, 32'hB);
        cpu_addr = 32'h12;
        #1;
        check("fwd_lowbits", cpu_rdata, 32'hB);
        cpu_addr  = 32'h14;
        ram_rdata = 32'h5555;
        #1;
        check("fwd_miss", cpu_rdata, 32'h5555);
        // A store in flight this cycle is not yet visible.
        cpu_we    = 1'b1;
        cpu_addr  = 32'h20;
        cpu_wdata = 32'hC;
        ram_rdata = 32'h77;
        #1;
        check("fwd_same_cycle", cpu_rdata, 32'h77);
        step();
        cpu_we = 1'b0;
        #1;
        check("fwd_next_cycle", cpu_rdata, 32'hC);

        // ---------------- full and stall ----------------
        store(32'h30, 32'hD);
        check("full_count", 32'(count), 4);
        cpu_we    = 1'b1;
        cpu_addr  = 32'h40;
        cpu_wdata = 32'hE;
        #1;
        check("full_stall", 32'(cpu_stall), 1);
        step();
        check("stall_count", 32'(count), 4);
        check("stall_hold", 32'(cpu_stall), 1);
        check("stall_head", 32'(ram_waddr), 32'h4);
        ram_ready = 1'b1;
        #1;
        check("pop_unstall", 32'(cpu_stall), 0);
        step();
        cpu_we = 1'b0;
        #1;
        check("swap_count", 32'(count), 4);
        exp_a = '{32'h4, 32'h8, 32'hC, 32'h10};
        exp_d = '{32'hB, 32'hC, 32'hD, 32'hE};
        for (int k = 0; k < 4; k++) begin
            check($sformatf("full_waddr%0d", k), 32'(ram_waddr), exp_a[k]);
            check($sformatf("full_wdata%0d", k), ram_wdata, exp_d[k]);
            step();
        end
        check("full_drained", 32'(empty), 1);

        // ---------------- wrap-around ----------------
        log_addr.delete();
        log_data.delete();
        tog = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cpu_we    = 1'b1;
            cpu_addr  = 32'(4 * i);
            cpu_wdata = 32'(i);
            accepted  = 1'b0;
            budget    = 0;
            while (!accepted && budget < 50) begin
                ram_ready = tog;
                tog       = !tog;
                #1;
                accepted = !cpu_stall;
                step();
                budget++;
            end
            if (!accepted) check($sformatf("wrap_push%0d_timeout", i), 32'(accepted), 1);
        end
        cpu_we    = 1'b0;
        ram_ready = 1'b1;
        budget    = 0;
        while (!empty && budget < 50) begin
            step();
            budget++;
        end
        check("wrap_drained", 32'(empty), 1);
        check("wrap_nwrites", 32'(log_addr.size()), 10);
        for (int i = 0; i < 10 && i < log_addr.size(); i++) begin
            check($sformatf("wrap_addr%0d", i), log_addr[i], 32'(i));
            check($sformatf("wrap_data%0d", i), log_data[i], 32'(i));
        end

        // ---------------- reset mid-operation ----------------
        ram_ready = 1'b0;
        store(32'h100, 32'h1);
        store(32'h104, 32'h2);
        store(32'h108, 32'h3);
        check("mid_count", 32'(count), 3);
        log_addr.delete();
        log_data.delete();
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_we", 32'(ram_we), 0);
        check("mid_rst_wdata", ram_wdata, 0);
        rst       = 1'b0;
        ram_ready = 1'b1;
        repeat (4) step();
        check("mid_no_writes", 32'(log_addr.size()), 0);
        check("mid_empty", 32'(empty), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_write_buffer.md
# dmem_write_buffer

Posted-write buffer between the RV32i pipelined CPU's data-memory port (`ALU_out`, `data_out`, `mem_w`, `data_in`) and the word-addressed data RAM. CPU stores are queued in a small FIFO and drained to RAM one per cycle whenever RAM signals ready, so a busy RAM does not stall stores until the FIFO fills. Loads are forwarded from the youngest matching pending store, so the CPU always reads the latest stored value.

## Interface
- `DEPTH`, 4: FIFO entries, power of two, 2..16.
- `AW`, 14: word-index width. The index is `cpu_addr[AW+1:2]`.
- `clk`  in  1  clock. All state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `cpu_addr`  in  32  byte address from CPU ALU_out. Bits [1:0] are ignored.
- `cpu_wdata`  in  32  store data from CPU data_out.
- `cpu_we`  in  1  store request, sampled each posedge.
- `cpu_rdata`  out  32  load data to CPU data_in. Combinational.
- `cpu_stall`  out  1  store cannot be accepted this cycle. Combinational.
- `ram_rdata`  in  32  RAM combinational read data at `cpu_addr[AW+1:2]`.
- `ram_ready`  in  1  RAM accepts a write this cycle.
- `ram_waddr`  out  AW  word index of the head entry.
- `ram_wdata`  out  32  data of the head entry.
- `ram_we`  out  1  head entry valid (FIFO not empty).
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `empty`  out  1  count == 0.

## Operation
- FIFO storage: a circular buffer of {AW-bit index, 32-bit data}. Head pointer `rd_ptr` and tail pointer `wr_ptr` are $clog2(DEPTH) bits wide and wrap modulo DEPTH. `count` is tracked separately.
- Pop: occurs when `ram_we && ram_ready`. `rd_ptr` advances by 1.
- Push: occurs when `cpu_we && !cpu_stall`. The entry {`cpu_addr[AW+1:2]`, `cpu_wdata`} is written at `wr_ptr`, and `wr_ptr` advances by 1.
- Stall: `cpu_stall = cpu_we && (count == DEPTH) && !ram_ready`. A full buffer with a pop in the same cycle accepts the push.
- Count update: `count` += push − pop. Simultaneous push and pop leave `count` unchanged.
- Forwarding:
  - `cpu_rdata` = data of the youngest valid entry whose index equals `cpu_addr[AW+1:2]`; otherwise `ram_rdata`.
  - Youngest means the entry closest to `wr_ptr−1`, searched backwards over `count` entries.
  - The head entry being popped in the current cycle still counts as valid for forwarding.
  - A store being pushed in the current cycle is not forwarded. Same-cycle load/store to one address returns the prior value.
- No write coalescing: repeated stores to one address occupy separate entries and drain in program order.
- RAM writes occur strictly in push order, one per accepted pop.
- Reset mid-operation: all pending entries are discarded without being written. `rst` has priority over push and pop.

## Timing
- Reset values:
  - `rd_ptr`, `wr_ptr`, `count` = 0; `empty` = 1; `ram_we` = 0.
  - `ram_waddr` = 0 and `ram_wdata` = 0; entry storage is cleared.
  - `cpu_stall` = 0; `cpu_rdata` = `ram_rdata`.
- Store-to-RAM latency: a store pushed at edge N appears on `ram_we`/`ram_waddr`/`ram_wdata` after edge N, when the buffer was empty. The RAM write completes at the first later edge with `ram_ready` = 1.
- `ram_waddr`/`ram_wdata` are stable while `ram_we` = 1 and `ram_ready` = 0.
- Store-to-load visibility: a load in the cycle after the push edge sees the new data through forwarding. After the drain, the load sees it through `ram_rdata`.
- Pointer wrap: after DEPTH pushes the pointers return to 0. Full and empty are distinguished only by `count`.
- Boundary cases:
  - Full + push + no pop: `cpu_stall` = 1, state unchanged. The CPU holds `cpu_we`/`cpu_addr`/`cpu_wdata`.
  - Empty + `ram_ready`: no write; `ram_we` = 0.

## Test plan
- Reset and idle: assert `rst` for 1 cycle -> `count`=0, `empty`=1, `ram_we`=0, `cpu_stall`=0. Drive `ram_rdata`=32'hDEAD_BEEF -> `cpu_rdata`=32'hDEAD_BEEF.
- Drain order: hold `ram_ready`=0 and store 32'h11 @0x0, 32'h22 @0x4, 32'h33 @0x8 -> `count`=3. Raise `ram_ready` -> `ram_waddr` sequence 0,1,2 with data 11,22,33 on consecutive edges, then `empty`=1.
- Forwarding: `ram_ready`=0; store 32'hA @0x10 then 32'hB @0x10; load 0x10 with `ram_rdata`=0 -> `cpu_rdata`=32'hB. Load 0x14 -> `ram_rdata` value.
- Full and stall: DEPTH=4, `ram_ready`=0; 4 stores -> `count`=4. A 5th store -> `cpu_stall`=1, `count` stays 4. Raise `ram_ready` in the same cycle -> stall drops, push accepted, `count` stays 4.
- Wrap-around: 10 stores of value i @ address 4*i with `ram_ready` toggling 1/0 -> RAM receives indices 0..9 in order with matching data. No loss or duplication.
- Reset mid-operation: 3 pending entries, pulse `rst` between edges -> `count`=0 and `ram_we`=0 immediately. None of the 3 entries is written to RAM.
